// File: rtl/databus_axi_read_bridge_pkg.sv
// Shared types and AXI constants for the databus AXI read bridge.
// Optional feature macro: DATABUS_AXI_READ_BRIDGE_SPLIT_4K_EN (see databus_burst_splitter).
package databus_axi_read_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;
  // Remaining-beat counters hold len+1, i.e. up to 256.
  localparam int         REM_W          = 9;

endpackage

// File: rtl/databus_burst_splitter.sv
// Computes the next AR burst (address, beats, arlen) and the address following it.
// With DATABUS_AXI_READ_BRIDGE_SPLIT_4K_EN defined, bursts are clipped at 4KB boundaries.
module databus_burst_splitter
  import databus_axi_read_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [AXI_ADDR_W-1:0] i_addr,
  input  logic [REM_W-1:0]      i_remaining,
  output logic [AXI_ADDR_W-1:0] o_addr,
  output logic [7:0]            o_arlen,
  output logic [REM_W-1:0]      o_beats,
  output logic [AXI_ADDR_W-1:0] o_next_addr
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [REM_W-1:0]      w_beats;
  logic [AXI_ADDR_W-1:0] w_next_addr;

`ifdef DATABUS_AXI_READ_BRIDGE_SPLIT_4K_EN
  logic [12:0] w_room;

  // Beats left before the 4KB page ends; always >= 1 for an aligned address.
  always_comb begin
    w_room  = (13'(BOUNDARY_4K) - {1'b0, i_addr[11:0]}) >> OFF_W;
    w_beats = i_remaining;
    if ({4'd0, i_remaining} > w_room) w_beats = w_room[REM_W-1:0];
  end
`else
  always_comb begin
    w_beats = i_remaining;
  end
`endif

  assign w_next_addr = i_addr + (AXI_ADDR_W'(w_beats) << OFF_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_addr      <= '0;
      o_arlen     <= '0;
      o_beats     <= '0;
      o_next_addr <= '0;
    end else if (i_load) begin
      o_addr      <= i_addr;
      o_arlen     <= 8'(w_beats - REM_W'(1));
      o_beats     <= w_beats;
      o_next_addr <= w_next_addr;
    end
  end

endmodule

// File: rtl/databus_axi_read_bridge.sv
// Serves one Versat unit databus read port from an AXI4 read master, one AR outstanding.
// DATABUS_AXI_READ_BRIDGE_SPLIT_4K_EN enables 4KB-safe burst splitting in the splitter.
module databus_axi_read_bridge
  import databus_axi_read_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  databus_valid_0,
  input  logic [AXI_ADDR_W-1:0] databus_addr_0,
  input  logic [7:0]            databus_len_0,
  output logic                  databus_ready_0,
  output logic [DATA_W-1:0]     databus_rdata_0,
  output logic                  databus_last_0,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  error
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_e                r_state, w_next_state;
  logic [REM_W-1:0]      r_remaining, r_burst_cnt;
  logic                  r_error;

  logic                  w_start, w_ar_hs, w_beat, w_burst_end, w_more;
  logic [REM_W-1:0]      w_rem_dec;
  logic                  w_split_load;
  logic [AXI_ADDR_W-1:0] w_split_in_addr, w_split_addr, w_split_next;
  logic [REM_W-1:0]      w_split_in_rem, w_split_beats;
  logic [7:0]            w_split_arlen;

  assign w_start     = (r_state == IDLE) && databus_valid_0;
  assign w_ar_hs     = m_axi_arvalid && m_axi_arready;
  assign w_beat      = m_axi_rvalid && m_axi_rready;
  assign w_burst_end = w_beat && (r_burst_cnt == REM_W'(1));
  assign w_rem_dec   = r_remaining - REM_W'(1);
  assign w_more      = (w_rem_dec != '0);

  // Splitter is reloaded at transfer start and at each burst end that has beats left.
  assign w_split_load    = w_start || (w_burst_end && w_more);
  assign w_split_in_addr = w_start ? {databus_addr_0[AXI_ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                   : w_split_next;
  assign w_split_in_rem  = w_start ? (REM_W'(databus_len_0) + REM_W'(1)) : w_rem_dec;

  databus_burst_splitter #(
    .DATA_W    (DATA_W),
    .AXI_ADDR_W(AXI_ADDR_W)
  ) u_splitter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_split_load),
    .i_addr     (w_split_in_addr),
    .i_remaining(w_split_in_rem),
    .o_addr     (w_split_addr),
    .o_arlen    (w_split_arlen),
    .o_beats    (w_split_beats),
    .o_next_addr(w_split_next)
  );

  assign m_axi_araddr    = w_split_addr;
  assign m_axi_arlen     = w_split_arlen;
  assign m_axi_arsize    = 3'(OFF_W);
  assign m_axi_arburst   = AXI_BURST_INCR;
  assign databus_rdata_0 = m_axi_rdata;
  assign error           = r_error;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next_state = ADDR;
      ADDR: if (w_ar_hs) w_next_state = DATA;
      DATA: if (w_burst_end) w_next_state = w_more ? ADDR : HOLD;
      // Stay here until the unit drops valid so the same request is not re-issued.
      HOLD: if (!databus_valid_0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid   = 1'b0;
    m_axi_rready    = 1'b0;
    databus_ready_0 = 1'b0;
    databus_last_0  = 1'b0;
    unique case (r_state)
      ADDR: m_axi_arvalid = 1'b1;
      DATA: begin
        m_axi_rready    = databus_valid_0;
        databus_ready_0 = m_axi_rvalid;
        databus_last_0  = m_axi_rvalid && (r_remaining == REM_W'(1));
      end
      default: ;
    endcase
  end

  // Beat accounting is by count; rlast only feeds the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_burst_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_start) begin
        r_remaining <= w_split_in_rem;
        r_error     <= 1'b0;
      end
      if (w_ar_hs) r_burst_cnt <= w_split_beats;
      if (w_beat) begin
        r_remaining <= w_rem_dec;
        r_burst_cnt <= r_burst_cnt - REM_W'(1);
        if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != (r_burst_cnt == REM_W'(1))))
          r_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_databus_axi_read_bridge.sv
// Directed bench for databus_axi_read_bridge: AXI slave model plus expected-AR/beat scoreboards.
module tb_databus_axi_read_bridge;

  localparam int DW = 32;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [AW-1:0] daddr;
  logic [7:0]    dlen;
  logic          dready, dlast, err;
  logic [DW-1:0] drdata;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;

  always #5 clk = ~clk;

  databus_axi_read_bridge #(.DATA_W(DW), .AXI_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .databus_valid_0(dv), .databus_addr_0(daddr), .databus_len_0(dlen),
    .databus_ready_0(dready), .databus_rdata_0(drdata), .databus_last_0(dlast),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .error(err)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic last; logic err; } beat_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } rb_t;

  ar_t   exp_ar[$];
  beat_t exp_bt[$];
  rb_t   rq[$];

  int nchk = 0, nerr = 0, nbeats = 0;
  int ar_stall = 0, gen_cnt = 0, resp_err_at = 0, rlast_err_at = 0;
  logic tog_mode = 1'b0;
  logic ar_hs_s = 1'b0, ar_wait_s = 1'b0, r_hs_s = 1'b0;
  logic [AW-1:0] ar_addr_s = '0;
  logic [7:0]    ar_len_s = '0;
  ar_t   mon_a;
  beat_t mon_b;

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference burst plan: expected ARs and beats, errors expected after beat err_after.
  task automatic push_req(input logic [AW-1:0] a, input logic [7:0] len, input int err_after);
    logic [AW-1:0] cur;
    int rem, n, k;
    cur = {a[AW-1:2], 2'b00};
    rem = int'(len) + 1;
    k   = 0;
    while (rem > 0) begin
      n = rem;
`ifdef DATABUS_AXI_READ_BRIDGE_SPLIT_4K_EN
      if (n > (4096 - int'(cur[11:0])) / 4) n = (4096 - int'(cur[11:0])) / 4;
`endif
      exp_ar.push_back('{cur, 8'(n - 1)});
      for (int j = 0; j < n; j++) begin
        k++;
        exp_bt.push_back('{dfun(cur + AW'(4 * j)), k == int'(len) + 1,
                           (err_after != 0) && (k > err_after)});
      end
      cur = cur + AW'(4 * n);
      rem = rem - n;
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [7:0] len);
    daddr   = a;
    dlen    = len;
    gen_cnt = 0;
    dv      = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_ar.size() == 0) && (exp_bt.size() == 0);
    end
    chk(tag, done, 1'b1);
  endtask

  // Unit keeps valid high after the last beat; no new AR and no rready may appear.
  task automatic hold_check(input string tag);
    tick();
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_hold_arvalid"}, arvalid, 1'b0);
      chk({tag, "_hold_rready"}, rready, 1'b0);
    end
    tick();
    dv = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: samples handshakes away from the active edge and scores them.
  always @(negedge clk) begin
    ar_hs_s   <= arvalid && arready && !rst;
    ar_wait_s <= arvalid && !arready;
    r_hs_s    <= rvalid && rready && !rst;
    ar_addr_s <= araddr;
    ar_len_s  <= arlen;
    if (tog_mode && exp_ar.size() == 0 && exp_bt.size() != 0)
      chk("rready_mirror", rready, dv);
    if (!rst && arvalid && arready) begin
      chk("ar_expected", exp_ar.size() != 0, 1'b1);
      if (exp_ar.size() != 0) begin
        mon_a = exp_ar.pop_front();
        chk("araddr", araddr, mon_a.addr);
        chk("arlen", arlen, mon_a.len);
      end
      chk("arsize", arsize, 3'd2);
      chk("arburst", arburst, 2'b01);
    end
    if (!rst && rvalid && rready) begin
      chk("beat_expected", exp_bt.size() != 0, 1'b1);
      if (exp_bt.size() != 0) begin
        mon_b = exp_bt.pop_front();
        chk("beat_ready", dready, 1'b1);
        chk("beat_data", drdata, mon_b.data);
        chk("beat_last", dlast, mon_b.last);
        chk("beat_error", err, mon_b.err);
      end
      nbeats++;
    end
  end

  // AXI read slave model.
  initial begin
    arready = 1'b1;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    forever begin
      tick();
      if (rst) begin
        rq.delete();
        rvalid = 1'b0;
      end else begin
        if (r_hs_s && rq.size() != 0) rq.delete(0);
        if (ar_hs_s) begin
          for (int k = 0; k <= int'(ar_len_s); k++) begin
            gen_cnt++;
            rq.push_back('{dfun(ar_addr_s + AW'(4 * k)),
                           (gen_cnt == resp_err_at) ? 2'b10 : 2'b00,
                           (k == int'(ar_len_s)) || (gen_cnt == rlast_err_at)});
          end
        end
        if (ar_wait_s && ar_stall > 0) ar_stall--;
        arready = (ar_stall == 0);
        rvalid  = (rq.size() != 0);
        if (rq.size() != 0) begin
          rdata = rq[0].data;
          rresp = rq[0].resp;
          rlast = rq[0].last;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    logic ok;
    rst = 1'b1; dv = 1'b0; daddr = '0; dlen = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_dready", dready, 1'b0);
    chk("rst_dlast", dlast, 1'b0);
    chk("rst_error", err, 1'b0);
    chk("rst_araddr", araddr, 64'h0);
    chk("rst_arlen", arlen, 8'h0);
    tick();
    rst = 1'b0;
    tick();

    // Aligned 8-beat transfer, valid held through HOLD.
    push_req(64'h1000, 8'd7, 0);
    start(64'h1000, 8'd7);
    wait_done("t1_done", 200);
    hold_check("t1");

    // Transfer straddling a 4KB page.
    push_req(64'h0FF8, 8'd7, 0);
    start(64'h0FF8, 8'd7);
    wait_done("t2_done", 200);
    hold_check("t2");

    // Unit valid toggling during DATA.
    push_req(64'h2000, 8'd7, 0);
    start(64'h2000, 8'd7);
    tick();
    tog_mode = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = (exp_ar.size() == 0) && (exp_bt.size() == 0);
      if (!ok) begin
        dv = ~dv;
        tick();
      end
    end
    dv = 1'b0;
    tog_mode = 1'b0;
    chk("t3_done", ok, 1'b1);
    tick();
    tick();

    // arready held low for 10 cycles.
    ar_stall = 10;
    tick();
    push_req(64'h3000, 8'd3, 0);
    start(64'h3000, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = arvalid;
    end
    chk("t4_arvalid_seen", ok, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_arvalid", arvalid, 1'b1);
      chk("t4_stall_araddr", araddr, 64'h3000);
      chk("t4_stall_arlen", arlen, 8'd3);
      @(negedge clk);
    end
    chk("t4_hs", arvalid && arready, 1'b1);
    chk("t4_hs_rready", rready, 1'b0);
    @(negedge clk);
    chk("t4_data_rready", rready, 1'b1);
    wait_done("t4_done", 100);
    hold_check("t4");

    // Bad rresp on beat 3; error sticky afterwards.
    resp_err_at = 3;
    push_req(64'h4000, 8'd7, 3);
    start(64'h4000, 8'd7);
    wait_done("t5a_done", 200);
    hold_check("t5a");
    chk("t5a_error_sticky", err, 1'b1);
    resp_err_at = 0;

    // Early rlast on beat 5; the new start clears the previous error.
    rlast_err_at = 5;
    push_req(64'h5000, 8'd7, 5);
    start(64'h5000, 8'd7);
    wait_done("t5b_done", 200);
    hold_check("t5b");
    chk("t5b_error", err, 1'b1);
    rlast_err_at = 0;

    // Single-beat transfer from an unaligned address.
    push_req(64'h8006, 8'd0, 0);
    start(64'h8006, 8'd0);
    wait_done("t7_done", 100);
    hold_check("t7");

    // Reset in DATA after beat 2 (error already raised by beat 1).
    resp_err_at = 1;
    push_req(64'h6000, 8'd7, 1);
    start(64'h6000, 8'd7);
    base = nbeats;
    for (int i = 0; i < 200 && (nbeats - base) < 2; i++) tick();
    chk("t6_two_beats", nbeats - base, 2);
    rst = 1'b1;
    dv  = 1'b0;
    tick();
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_rready", rready, 1'b0);
    chk("t6_dready", dready, 1'b0);
    chk("t6_dlast", dlast, 1'b0);
    chk("t6_error", err, 1'b0);
    exp_ar.delete();
    exp_bt.delete();
    resp_err_at = 0;
    tick();
    rst = 1'b0;
    tick();
    push_req(64'h7000, 8'd3, 0);
    start(64'h7000, 8'd3);
    wait_done("t6_after_done", 100);
    hold_check("t6_after");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
